// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port, synchronous-read data memory (M0 = core, M1 = debug/DMA).
// Define DMEM_ARB_RR_EN for round-robin tie-break in IDLE; otherwise M0 wins ties.

module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} ownerStateT;

  ownerStateT    state;
  logic [CW-1:0] holdCnt;
  logic          yieldFlag;
  logic          yieldTo;
  logic          rdPending;
  logic          rdOwner;
`ifdef DMEM_ARB_RR_EN
  logic          lastWinner;
`endif

  logic          anyGnt;
  logic          sel;
  logic          selWe;
  logic          selLock;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selWdata;
  logic [CW-1:0] holdNext;
  logic          forceRel;

  always_comb begin
    anyGnt = 1'b0;
    sel    = 1'b0;
    case (state)
      StLock0: begin
        anyGnt = m0_req;
        sel    = 1'b0;
      end
      StLock1: begin
        anyGnt = m1_req;
        sel    = 1'b1;
      end
      default: begin
        if (yieldFlag && (yieldTo ? m1_req : m0_req)) begin
          anyGnt = 1'b1;
          sel    = yieldTo;
        end else if (m0_req && m1_req) begin
          anyGnt = 1'b1;
`ifdef DMEM_ARB_RR_EN
          sel    = ~lastWinner;
`else
          sel    = 1'b0;
`endif
        end else if (m0_req || m1_req) begin
          anyGnt = 1'b1;
          sel    = m1_req;
        end
      end
    endcase
    // Grants must read as zero for the whole time reset is held.
    if (!rst) anyGnt = 1'b0;
  end

  assign selWe    = sel ? m1_we    : m0_we;
  assign selLock  = sel ? m1_lock  : m0_lock;
  assign selAddr  = sel ? m1_addr  : m0_addr;
  assign selWdata = sel ? m1_wdata : m0_wdata;

  // Number of locked grants in the current run, counting this one.
  assign holdNext = (state == StIdle) ? CW'(1) : holdCnt + CW'(1);
  assign forceRel = anyGnt && selLock && (holdNext == CW'(MAX_HOLD));

  assign m0_gnt    = anyGnt & ~sel;
  assign m1_gnt    = anyGnt & sel;
  assign mem_en    = anyGnt;
  assign mem_we    = anyGnt & selWe;
  assign mem_addr  = anyGnt ? selAddr  : '0;
  assign mem_wdata = anyGnt ? selWdata : '0;

  assign m0_rvalid = rdPending & ~rdOwner;
  assign m1_rvalid = rdPending & rdOwner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      holdCnt    <= '0;
      yieldFlag  <= 1'b0;
      yieldTo    <= 1'b0;
      rdPending  <= 1'b0;
      rdOwner    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      lastWinner <= 1'b1;
`endif
    end else begin
      yieldFlag <= forceRel;
      if (forceRel) yieldTo <= ~sel;
      rdPending <= anyGnt & ~selWe;
      if (anyGnt) rdOwner <= sel;
`ifdef DMEM_ARB_RR_EN
      if (anyGnt) lastWinner <= sel;
`endif
      if (forceRel) begin
        state   <= StIdle;
        holdCnt <= holdNext;
      end else if (state == StIdle) begin
        if (anyGnt && selLock) begin
          state   <= sel ? StLock1 : StLock0;
          holdCnt <= holdNext;
        end
      end else if (!anyGnt || !selLock) begin
        state   <= StIdle;
        holdCnt <= '0;
      end else begin
        holdCnt <= holdNext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level owner/lock model plus an emulated memory.
// Honours DMEM_ARB_RR_EN the same way as the design (round-robin vs fixed-priority ties).

module tb_dmem_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_HOLD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  bit checkOn = 1'b0;

  logic [DW-1:0] envMem [256];
  logic [DW-1:0] shadow [256];

  // Model: current lock owner (-1 none), grants in this lock run, pending yield target, pending read.
  int            mOwner, mCount, mYield, mPend;
  logic [DW-1:0] mPendData;
`ifdef DMEM_ARB_RR_EN
  int            mLast;
`endif

  bit            cRst, cMemEn, cMemWe;
  bit            cWe [2];
  bit            cLock [2];
  logic [AW-1:0] cAddr [2];
  logic [DW-1:0] cWdata [2];
  logic [AW-1:0] cMemAddr;
  logic [DW-1:0] cMemWdata;
  int            cG;

  int            eg;
  bit            expWe, expRv0, expRv1;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mOwner = -1;
    mCount = 0;
    mYield = -1;
    mPend  = -1;
    mPendData = '0;
`ifdef DMEM_ARB_RR_EN
    mLast = 1;
`endif
  endtask

  function automatic int expGrant(input bit r0, input bit r1);
    bit r [2];
    r[0] = r0;
    r[1] = r1;
    if (mOwner >= 0) return r[mOwner] ? mOwner : -1;
    if (mYield >= 0 && r[mYield]) return mYield;
    if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      return 1 - mLast;
`else
      return 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic modelStep();
    int ny;
    if (!cRst || !rst) begin
      resetModel();
      return;
    end
    ny    = -1;
    mPend = -1;
    if (cG >= 0) begin
`ifdef DMEM_ARB_RR_EN
      mLast = cG;
`endif
      if (cWe[cG]) shadow[cAddr[cG][7:0]] = cWdata[cG];
      else begin
        mPend     = cG;
        mPendData = shadow[cAddr[cG][7:0]];
      end
    end
    if (mOwner >= 0) begin
      if (cG < 0) mOwner = -1;
      else begin
        mCount++;
        if (!cLock[cG]) mOwner = -1;
        else if (mCount == int'(MAX_HOLD)) begin
          mOwner = -1;
          ny     = 1 - cG;
        end
      end
    end else if (cG >= 0 && cLock[cG]) begin
      mCount = 1;
      if (mCount == int'(MAX_HOLD)) ny = 1 - cG;
      else mOwner = cG;
    end
    mYield = ny;
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    cMemEn    = mem_en;
    cMemWe    = mem_we;
    cMemAddr  = mem_addr;
    cMemWdata = mem_wdata;
    if (checkOn) begin
      cRst      = rst;
      cWe[0]    = m0_we;    cWe[1]    = m1_we;
      cLock[0]  = m0_lock;  cLock[1]  = m1_lock;
      cAddr[0]  = m0_addr;  cAddr[1]  = m1_addr;
      cWdata[0] = m0_wdata; cWdata[1] = m1_wdata;
      eg        = rst ? expGrant(m0_req, m1_req) : -1;
      cG        = eg;
      expWe     = (eg >= 0) && (eg == 0 ? m0_we : m1_we);
      expAddr   = (eg < 0) ? '0 : (eg == 0 ? m0_addr : m1_addr);
      expWdata  = (eg < 0) ? '0 : (eg == 0 ? m0_wdata : m1_wdata);
      expRv0    = rst && (mPend == 0);
      expRv1    = rst && (mPend == 1);
      check("m0_gnt", m0_gnt, eg == 0);
      check("m1_gnt", m1_gnt, eg == 1);
      check("mem_en", mem_en, eg >= 0);
      check("mem_we", mem_we, expWe);
      check("mem_addr", mem_addr, expAddr);
      check("mem_wdata", mem_wdata, expWdata);
      check("m0_rvalid", m0_rvalid, expRv0);
      check("m1_rvalid", m1_rvalid, expRv1);
      check("m0_rdata", m0_rdata, expRv0 ? mPendData : '0);
      check("m1_rdata", m1_rdata, expRv1 ? mPendData : '0);
    end
  end

  always @(posedge clk) if (checkOn) modelStep();

  // Synchronous-read memory behind the arbiter.
  always @(posedge clk) begin
    if (cMemEn) begin
      if (cMemWe) envMem[cMemAddr[7:0]] = cMemWdata;
      else mem_rdata <= envMem[cMemAddr[7:0]];
    end
  end

  task automatic clearInputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic setM(input int who, input bit req, input bit we, input bit lock,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (who == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [9:0] g0, g1;
  bit         anyRv;
  logic [3:0] expAlt0, expAlt1;
  int         lockPct, reqPct;

  initial begin
    for (int i = 0; i < 256; i++) begin
      envMem[i] = $urandom;
      shadow[i] = envMem[i];
    end
    resetModel();

    // Reset values, with requests active to show grants stay low.
    setM(0, 1, 1, 1, 32'h44, 32'h1234);
    setM(1, 1, 0, 0, 32'h48, 32'h5678);
    @(posedge clk);
    @(negedge clk);
    check("rst m0_gnt", m0_gnt, 0);
    check("rst m1_gnt", m1_gnt, 0);
    check("rst mem_en", mem_en, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst rvalid", {m0_rvalid, m1_rvalid}, 0);
    check("rst rdata", {m0_rdata, m1_rdata}, 0);
    checkOn = 1'b1;
    doReset();

    // Single M0 read.
    envMem[8'h10] = 32'hDEADBEEF;
    shadow[8'h10] = 32'hDEADBEEF;
    setM(0, 1, 0, 0, 32'h10, '0);
    @(negedge clk);
    check("t2 m0_gnt c0", m0_gnt, 1);
    check("t2 mem_en c0", mem_en, 1);
    check("t2 mem_addr c0", mem_addr, 32'h10);
    nextCycle();
    clearInputs();
    @(negedge clk);
    check("t2 m0_rvalid c1", m0_rvalid, 1);
    check("t2 m0_rdata c1", m0_rdata, 32'hDEADBEEF);
    check("t2 m1_rvalid c1", m1_rvalid, 0);
    nextCycle();

    // Both request reads continuously, no lock.
    doReset();
    setM(0, 1, 0, 0, 32'h3, '0);
    setM(1, 1, 0, 0, 32'h5, '0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      g0[c] = m0_gnt;
      g1[c] = m1_gnt;
      nextCycle();
    end
`ifdef DMEM_ARB_RR_EN
    expAlt0 = 4'b0101;
    expAlt1 = 4'b1010;
`else
    expAlt0 = 4'b1111;
    expAlt1 = 4'b0000;
`endif
    check("t3 m0 grant pattern", g0[3:0], expAlt0);
    check("t3 m1 grant pattern", g1[3:0], expAlt1);

    // M1 locked writes hold off M0.
    doReset();
    g0 = '0; g1 = '0; anyRv = 0;
    for (int c = 0; c < 6; c++) begin
      setM(1, c < 4, 1, c < 3, 32'h20, 32'h55);
      setM(0, c >= 1, 0, 0, 32'h30, '0);
      @(negedge clk);
      g0[c] = m0_gnt;
      g1[c] = m1_gnt;
      if (c < 5) anyRv = anyRv | m0_rvalid | m1_rvalid;
      if (c == 5) check("t4 m0_rvalid after grant", m0_rvalid, 1);
      nextCycle();
    end
    check("t4 m0 grant pattern", g0[4:0], 5'b10000);
    check("t4 m1 grant pattern", g1[4:0], 5'b01111);
    check("t4 no rvalid on writes", anyRv, 0);
    clearInputs();

    // M0 locks continuously against a requesting M1: forced release after MAX_HOLD grants.
    doReset();
    setM(0, 1, 0, 1, 32'h7, '0);
    setM(1, 1, 0, 0, 32'h9, '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      g0[c] = m0_gnt;
      g1[c] = m1_gnt;
      nextCycle();
    end
    check("t5 m0 grants c0-7", g0[7:0], 8'hFF);
    check("t5 m1 yield grant c8", {g0[8], g1[8]}, 2'b01);
    check("t5 m0 regrant c9", {g0[9], g1[9]}, 2'b10);
    clearInputs();

    // Owner drops req while locked.
    doReset();
    setM(0, 1, 0, 1, 32'h2, '0);
    setM(1, 1, 0, 0, 32'h4, '0);
    @(negedge clk);
    check("t6 m0 lock grant", m0_gnt, 1);
    nextCycle();
    m0_req = 0;
    @(negedge clk);
    check("t6 m1 blocked on drop", m1_gnt, 0);
    nextCycle();
    @(negedge clk);
    check("t6 m1 granted after drop", m1_gnt, 1);
    nextCycle();
    clearInputs();

    // Reset right after an accepted read drops the pending rvalid.
    doReset();
    setM(0, 1, 0, 0, 32'h11, '0);
    @(negedge clk);
    check("t7 read accepted", m0_gnt, 1);
    nextCycle();
    rst = 1'b0;
    #1;
    check("t7 async m0_rvalid", m0_rvalid, 0);
    check("t7 async m0_gnt", m0_gnt, 0);
    check("t7 async mem_en", mem_en, 0);
    check("t7 async mem_addr", mem_addr, 0);
    check("t7 async m0_rdata", m0_rdata, 0);
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    anyRv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      anyRv = anyRv | m0_rvalid | m1_rvalid;
      nextCycle();
    end
    check("t7 no replayed rvalid", anyRv, 0);

    // Randomized traffic with varying lock density.
    for (int blk = 0; blk < 12; blk++) begin
      lockPct = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 60 : 97;
      reqPct  = (blk % 2 == 0) ? 90 : 60;
      if (blk == 6) doReset();
      for (int cyc = 0; cyc < 200; cyc++) begin
        setM(0, $urandom_range(99) < reqPct, $urandom_range(1) == 1,
             $urandom_range(99) < lockPct, AW'($urandom_range(15)), $urandom);
        setM(1, $urandom_range(99) < reqPct, $urandom_range(1) == 1,
             $urandom_range(99) < lockPct, AW'($urandom_range(15)), $urandom);
        nextCycle();
      end
    end
    clearInputs();
    nextCycle();
    checkOn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
